// File: rtl/udp_rx.sv
// -----------------------------------------------------------------------------
// udp_rx: GMII receive-side UDP/IPv4 frame parser.
//
// Consumes the raw GMII byte stream (preamble, SFD, Ethernet header, IPv4
// header, UDP header, payload, FCS). It keeps frames whose destination MAC,
// EtherType, IPv4 version/IHL, protocol, destination IP and destination UDP
// port all match. Accepted payload is emitted as big-endian 32-bit words.
// The FCS is not checked here; CRC checking lives in a separate block.
//
// Ports:
//   clk            in   GMII receive clock, all logic on the rising edge
//   rst            in   synchronous active-high reset, silent frame abort
//   rx_dv          in   GMII receive data valid
//   rx_er          in   GMII receive error
//   rxd[7:0]       in   GMII receive byte
//   data_out[31:0] out  payload word, first byte in [31:24]
//   data_valid     out  one-cycle strobe, data_out holds a new word
//   rx_done        out  one-cycle strobe, accepted frame payload complete
//   rx_data_length out  payload bytes of last accepted frame, held
//   rx_error       out  one-cycle strobe, frame aborted by rx_dv=0 / rx_er=1
//   rx_state[2:0]  out  current FSM state for debug
//
// Output semantics: there is no handshake. Every strobe is a registered
// single-cycle pulse asserted on the edge that samples the byte causing it;
// data_out is only meaningful while data_valid is high. The receiver cannot
// stall the GMII stream, so there is no ready signal.
// -----------------------------------------------------------------------------
module udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        rx_done,
  output logic [15:0] rx_data_length,
  output logic        rx_error,
  output logic [2:0]  rx_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_MAC      = 3'd2,
    S_HEADER   = 3'd3,
    S_DATA     = 3'd4,
    S_DROP     = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;             // byte index inside MAC / HEADER
  logic [15:0] r_remain, w_remain;       // payload bytes still to come
  logic [3:0]  r_pre_cnt, w_pre_cnt;     // 0x55 count, saturates at 8
  logic        r_mac_local, w_mac_local; // dest MAC still matches LOCAL_MAC
  logic        r_mac_bcast, w_mac_bcast; // dest MAC still matches broadcast
  logic [15:0] r_udp_len, w_udp_len;
  logic [31:0] r_asm, w_asm;             // newest byte in [7:0]
  logic [1:0]  r_fill, w_fill;           // bytes already held in r_asm
  logic [31:0] r_data_out, w_data_out;
  logic        r_data_valid, w_data_valid;
  logic        r_rx_done, w_rx_done;
  logic        r_rx_error, w_rx_error;
  logic [15:0] r_rx_data_length, w_rx_data_length;

  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic [7:0]  w_port_byte;
  logic [31:0] w_word;
  logic        w_bad;

  // Expected byte of each address field at the current counter value.
  always_comb begin
    w_mac_byte = 8'h00;
    case (r_cnt[2:0])
      3'd0:    w_mac_byte = LOCAL_MAC[47:40];
      3'd1:    w_mac_byte = LOCAL_MAC[39:32];
      3'd2:    w_mac_byte = LOCAL_MAC[31:24];
      3'd3:    w_mac_byte = LOCAL_MAC[23:16];
      3'd4:    w_mac_byte = LOCAL_MAC[15:8];
      3'd5:    w_mac_byte = LOCAL_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
    // Header bytes 16..19 hold the IP; low two counter bits pick the byte.
    w_ip_byte = 8'h00;
    case (r_cnt[1:0])
      2'd0:    w_ip_byte = LOCAL_IP[31:24];
      2'd1:    w_ip_byte = LOCAL_IP[23:16];
      2'd2:    w_ip_byte = LOCAL_IP[15:8];
      default: w_ip_byte = LOCAL_IP[7:0];
    endcase
    // Header bytes 22 (even) and 23 (odd) hold the destination port.
    w_port_byte = r_cnt[0] ? LOCAL_PORT[7:0] : LOCAL_PORT[15:8];
  end

  // Next-state and output logic.
  always_comb begin
    w_state          = r_state;
    w_cnt            = r_cnt;
    w_remain         = r_remain;
    w_pre_cnt        = r_pre_cnt;
    w_mac_local      = r_mac_local;
    w_mac_bcast      = r_mac_bcast;
    w_udp_len        = r_udp_len;
    w_asm            = r_asm;
    w_fill           = r_fill;
    w_data_out       = r_data_out;
    w_data_valid     = 1'b0;
    w_rx_done        = 1'b0;
    w_rx_error       = 1'b0;
    w_rx_data_length = r_rx_data_length;
    w_word           = 32'h0;
    w_bad            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_dv) begin
          if (rxd == 8'h55) begin
            w_state   = S_PREAMBLE;
            w_pre_cnt = 4'd1;
          end else begin
            w_state = S_DROP;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) w_state = S_IDLE;
      end

      default: begin
        // PREAMBLE, MAC, HEADER, DATA share the abort handling.
        if (!rx_dv) begin
          w_rx_error = 1'b1;
          w_state    = S_IDLE;
        end else if (rx_er) begin
          w_rx_error = 1'b1;
          w_state    = S_DROP;
        end else begin
          case (r_state)
            S_PREAMBLE: begin
              if (rxd == 8'h55) begin
                if (r_pre_cnt != 4'd8) w_pre_cnt = r_pre_cnt + 4'd1;
              end else if (rxd == 8'hD5 && r_pre_cnt <= 4'd7) begin
                w_state = S_MAC;
                w_cnt   = 16'd0;
              end else begin
                w_state = S_DROP;
              end
            end

            S_MAC: begin
              w_cnt = r_cnt + 16'd1;
              if (r_cnt < 16'd6) begin
                // Local and broadcast are tracked separately so a mix of
                // the two patterns is rejected.
                w_mac_local = ((r_cnt == 16'd0) || r_mac_local) && (rxd == w_mac_byte);
                w_mac_bcast = ((r_cnt == 16'd0) || r_mac_bcast) && (rxd == 8'hFF);
                if (!w_mac_local && !w_mac_bcast) w_state = S_DROP;
              end else if (r_cnt == 16'd12) begin
                if (rxd != 8'h08) w_state = S_DROP;
              end else if (r_cnt == 16'd13) begin
                if (rxd != 8'h00) begin
                  w_state = S_DROP;
                end else begin
                  w_state = S_HEADER;
                  w_cnt   = 16'd0;
                end
              end
            end

            S_HEADER: begin
              w_cnt = r_cnt + 16'd1;
              if (r_cnt == 16'd0) begin
                w_bad = (rxd != 8'h45);
              end else if (r_cnt == 16'd9) begin
                w_bad = (rxd != 8'h11);
              end else if (r_cnt >= 16'd16 && r_cnt <= 16'd19) begin
                w_bad = (rxd != w_ip_byte);
              end else if (r_cnt == 16'd22 || r_cnt == 16'd23) begin
                w_bad = (rxd != w_port_byte);
              end else if (r_cnt == 16'd24) begin
                w_udp_len[15:8] = rxd;
              end else if (r_cnt == 16'd25) begin
                w_udp_len[7:0] = rxd;
              end else if (r_cnt == 16'd27) begin
                if (r_udp_len < 16'd8) begin
                  w_rx_error = 1'b1;
                  w_state    = S_DROP;
                end else if (r_udp_len == 16'd8) begin
                  w_rx_done        = 1'b1;
                  w_rx_data_length = 16'd0;
                  w_state          = S_DROP;
                end else begin
                  w_state  = S_DATA;
                  w_remain = r_udp_len - 16'd8;
                  w_fill   = 2'd0;
                end
              end
              if (w_bad) w_state = S_DROP;
            end

            S_DATA: begin
              w_asm    = {r_asm[23:0], rxd};
              w_remain = r_remain - 16'd1;
              w_fill   = r_fill + 2'd1;
              if (r_remain == 16'd1) begin
                // Final byte: left-justify whatever is held, zero the rest.
                case (r_fill)
                  2'd0:    w_word = {rxd, 24'h0};
                  2'd1:    w_word = {r_asm[7:0], rxd, 16'h0};
                  2'd2:    w_word = {r_asm[15:0], rxd, 8'h0};
                  default: w_word = {r_asm[23:0], rxd};
                endcase
                w_data_out       = w_word;
                w_data_valid     = 1'b1;
                w_rx_done        = 1'b1;
                w_rx_data_length = r_udp_len - 16'd8;
                w_state          = S_DROP;
              end else if (r_fill == 2'd3) begin
                w_data_out   = {r_asm[23:0], rxd};
                w_data_valid = 1'b1;
              end
            end

            default: w_state = S_DROP;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= 16'd0;
      r_remain         <= 16'd0;
      r_pre_cnt        <= 4'd0;
      r_mac_local      <= 1'b0;
      r_mac_bcast      <= 1'b0;
      r_udp_len        <= 16'd0;
      r_asm            <= 32'h0;
      r_fill           <= 2'd0;
      r_data_out       <= 32'h0;
      r_data_valid     <= 1'b0;
      r_rx_done        <= 1'b0;
      r_rx_error       <= 1'b0;
      r_rx_data_length <= 16'd0;
    end else begin
      r_state          <= w_state;
      r_cnt            <= w_cnt;
      r_remain         <= w_remain;
      r_pre_cnt        <= w_pre_cnt;
      r_mac_local      <= w_mac_local;
      r_mac_bcast      <= w_mac_bcast;
      r_udp_len        <= w_udp_len;
      r_asm            <= w_asm;
      r_fill           <= w_fill;
      r_data_out       <= w_data_out;
      r_data_valid     <= w_data_valid;
      r_rx_done        <= w_rx_done;
      r_rx_error       <= w_rx_error;
      r_rx_data_length <= w_rx_data_length;
    end
  end

  assign data_out       = r_data_out;
  assign data_valid     = r_data_valid;
  assign rx_done        = r_rx_done;
  assign rx_error       = r_rx_error;
  assign rx_data_length = r_rx_data_length;
  assign rx_state       = r_state;

endmodule

// File: tb/tb_udp_rx.sv
// -----------------------------------------------------------------------------
// tb_udp_rx: directed frame table for udp_rx. Each record describes one GMII
// frame and the words, done/error pulses and held length it must produce.
// -----------------------------------------------------------------------------
module tb_udp_rx;

  localparam logic [47:0] L_MAC  = 48'h000A3501FEC0;
  localparam logic [31:0] L_IP   = 32'hC0A80002;
  localparam logic [15:0] L_PORT = 16'h1F90;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic [31:0] data_out;
  logic        data_valid;
  logic        rx_done;
  logic [15:0] rx_data_length;
  logic        rx_error;
  logic [2:0]  rx_state;

  udp_rx #(
    .LOCAL_MAC (L_MAC),
    .LOCAL_IP  (L_IP),
    .LOCAL_PORT(L_PORT)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .rx_dv         (rx_dv),
    .rx_er         (rx_er),
    .rxd           (rxd),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .rx_done       (rx_done),
    .rx_data_length(rx_data_length),
    .rx_error      (rx_error),
    .rx_state      (rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector record ----------------
  // kind: 0 = rx_dv drops at payload byte abort_at, 1 = rx_er on that byte,
  //       2 = rst asserted at that byte.
  typedef struct {
    string       name;
    int          npre;
    logic [47:0] mac;
    logic [15:0] etype;
    logic [7:0]  ver;
    logic [7:0]  proto;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] ulen;
    int          nsent;
    int          abort_at;
    int          kind;
    bit          fcs_er;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_done;
    logic [15:0] exp_len;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] cur_exp_len = 16'd0;
  logic [15:0] last_len = 16'd0;

  function automatic vec_t mk(input string name, input int npre, input logic [47:0] mac,
                              input logic [15:0] etype, input logic [7:0] ver,
                              input logic [7:0] proto, input logic [31:0] ip,
                              input logic [15:0] port, input logic [15:0] ulen,
                              input int nsent, input int abort_at, input int kind,
                              input bit fcs_er, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input bit exp_done,
                              input logic [15:0] exp_len, input bit exp_err);
    vec_t v;
    v.name = name; v.npre = npre; v.mac = mac; v.etype = etype; v.ver = ver;
    v.proto = proto; v.ip = ip; v.port = port; v.ulen = ulen; v.nsent = nsent;
    v.abort_at = abort_at; v.kind = kind; v.fcs_er = fcs_er; v.nw = nw;
    v.w0 = w0; v.w1 = w1; v.exp_done = exp_done; v.exp_len = exp_len;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no word", data_out);
      end else begin
        check("data_word", data_out, exp_q.pop_front());
      end
    end
    if (rx_done) begin
      done_cnt++;
      check("done_length", {16'h0, rx_data_length}, {16'h0, cur_exp_len});
    end
    if (rx_error) err_cnt++;
    if (rx_done && rx_error) begin
      checks++;
      errors++;
      $display("FAIL done_error_overlap: got both strobes expected at most one");
    end
  end

  // ---------------- driver ----------------
  task automatic put(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0]  fb[$];
    logic [15:0] tot;
    int          pay0;
    int          d0;
    int          e0;
    d0 = done_cnt;
    e0 = err_cnt;
    cur_exp_len = v.exp_len;
    if (v.nw > 0) exp_q.push_back(v.w0);
    if (v.nw > 1) exp_q.push_back(v.w1);

    for (int i = 0; i < v.npre; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fb.push_back(v.mac[i*8 +: 8]);
    fb.push_back(8'h00); fb.push_back(8'h11); fb.push_back(8'h22);
    fb.push_back(8'h33); fb.push_back(8'h44); fb.push_back(8'h55);
    fb.push_back(v.etype[15:8]); fb.push_back(v.etype[7:0]);
    tot = v.ulen + 16'd20;
    fb.push_back(v.ver);        fb.push_back(8'h00);
    fb.push_back(tot[15:8]);    fb.push_back(tot[7:0]);
    fb.push_back(8'h00);        fb.push_back(8'h00);
    fb.push_back(8'h40);        fb.push_back(8'h00);
    fb.push_back(8'h40);        fb.push_back(v.proto);
    fb.push_back(8'h00);        fb.push_back(8'h00);
    fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h00); fb.push_back(8'h01);
    fb.push_back(v.ip[31:24]); fb.push_back(v.ip[23:16]);
    fb.push_back(v.ip[15:8]);  fb.push_back(v.ip[7:0]);
    fb.push_back(8'h04);       fb.push_back(8'hD2);
    fb.push_back(v.port[15:8]); fb.push_back(v.port[7:0]);
    fb.push_back(v.ulen[15:8]); fb.push_back(v.ulen[7:0]);
    fb.push_back(8'h00);       fb.push_back(8'h00);
    pay0 = fb.size();
    for (int i = 0; i < v.nsent; i++) fb.push_back(8'(i + 1));
    fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);

    for (int i = 0; i < fb.size(); i++) begin
      if (v.abort_at >= 0 && i == pay0 + v.abort_at) begin
        if (v.kind == 0) begin
          put(1'b0, 1'b0, 8'h00);
          @(negedge clk); #1;
          check({v.name, "/abort_state"}, {29'h0, rx_state}, 32'd0);
          break;
        end else if (v.kind == 1) begin
          put(1'b1, 1'b1, fb[i]);
          continue;
        end else begin
          @(negedge clk);
          rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
          @(negedge clk); #1;
          check({v.name, "/rst_data_out"}, data_out, 32'h0);
          check({v.name, "/rst_valid"}, {31'h0, data_valid}, 32'd0);
          check({v.name, "/rst_done"}, {31'h0, rx_done}, 32'd0);
          check({v.name, "/rst_error"}, {31'h0, rx_error}, 32'd0);
          check({v.name, "/rst_length"}, {16'h0, rx_data_length}, 32'd0);
          check({v.name, "/rst_state"}, {29'h0, rx_state}, 32'd0);
          rst = 1'b0;
          last_len = 16'd0;
          break;
        end
      end
      put(1'b1, v.fcs_er && (i == fb.size() - 1), fb[i]);
    end

    repeat (4) put(1'b0, 1'b0, 8'h00);
    @(negedge clk); #1;
    if (v.exp_done) last_len = v.exp_len;
    check({v.name, "/done_count"}, done_cnt - d0, {31'h0, v.exp_done});
    check({v.name, "/error_count"}, err_cnt - e0, {31'h0, v.exp_err});
    check({v.name, "/words_left"}, exp_q.size(), 32'd0);
    check({v.name, "/idle_state"}, {29'h0, rx_state}, 32'd0);
    check({v.name, "/held_length"}, {16'h0, rx_data_length}, {16'h0, last_len});
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_data_out", data_out, 32'h0);
    check("reset_valid", {31'h0, data_valid}, 32'd0);
    check("reset_done", {31'h0, rx_done}, 32'd0);
    check("reset_error", {31'h0, rx_error}, 32'd0);
    check("reset_length", {16'h0, rx_data_length}, 32'd0);
    check("reset_state", {29'h0, rx_state}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //                 name          pre mac              etype     ver    proto  ip            port      ulen  sent abt kind fer nw w0            w1            done len  err
    vecs.push_back(mk("basic",       7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 2, 32'h01020304, 32'h05060708, 1, 16'd8, 0));
    vecs.push_back(mk("bcast5",      7, 48'hFFFFFFFFFFFF, 16'h0800, 8'h45, 8'h11, L_IP,        L_PORT,   16'd13, 8, -1, 0, 0, 2, 32'h01020304, 32'h05000000, 1, 16'd5, 0));
    vecs.push_back(mk("bad_ip",      7, L_MAC,           16'h0800, 8'h45, 8'h11, 32'hC0A80009, L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("bad_port",    7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         16'h1F91, 16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("bad_proto",   7, L_MAC,           16'h0800, 8'h45, 8'h06, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("good3",       7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd11, 3, -1, 0, 0, 1, 32'h01020300, 32'h0, 1, 16'd3, 0));
    vecs.push_back(mk("abort_dv",    7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8,  2, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 1));
    vecs.push_back(mk("after_abort", 7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd14, 6, -1, 0, 0, 2, 32'h01020304, 32'h05060000, 1, 16'd6, 0));
    vecs.push_back(mk("len8",        7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd8,  0, -1, 0, 0, 0, 32'h0, 32'h0, 1, 16'd0, 0));
    vecs.push_back(mk("len4",        7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd4,  0, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 1));
    vecs.push_back(mk("bad_mac",     7, 48'h000A3501FEC1, 16'h0800, 8'h45, 8'h11, L_IP,        L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("bad_etype",   7, L_MAC,           16'h0806, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("bad_ver",     7, L_MAC,           16'h0800, 8'h46, 8'h11, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("pre8",        8, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 0, 32'h0, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("pre1",        1, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd9,  1, -1, 0, 0, 1, 32'h01000000, 32'h0, 1, 16'd1, 0));
    vecs.push_back(mk("len12_fcser", 7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd12, 4, -1, 0, 1, 1, 32'h01020304, 32'h0, 1, 16'd4, 0));
    vecs.push_back(mk("abort_er",    7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8,  2, 1, 0, 0, 32'h0, 32'h0, 0, 16'd0, 1));
    vecs.push_back(mk("rst_mid",     7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8,  5, 2, 0, 1, 32'h01020304, 32'h0, 0, 16'd0, 0));
    vecs.push_back(mk("after_rst",   7, L_MAC,           16'h0800, 8'h45, 8'h11, L_IP,         L_PORT,   16'd16, 8, -1, 0, 0, 2, 32'h01020304, 32'h05060708, 1, 16'd8, 0));

    for (int k = 0; k < vecs.size(); k++) send_frame(vecs[k]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
